// File: rtl/oc_bus_arbiter_pkg.sv
// Shared definitions for the open-collector line arbiter: FSM encoding,
// default timing constants and the round-robin pointer helper.
package oc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam int DEF_GAP      = 2;
  localparam int DEF_MAX_HOLD = 16;
  localparam int GAP_CNT_W    = 4;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/oc_bus_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping circularly over N requesters.
module rr_pick
  import oc_bus_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Walk from the farthest position back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/oc_bus_arbiter.sv
// Round-robin owner arbiter for a shared wired-AND open-collector line.
// Define OCARB_TIMEOUT_EN to add the MAX_HOLD forced-revoke timer and tmo pulse.
module oc_bus_arbiter
  import oc_bus_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int GAP      = DEF_GAP,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 line,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 fault,
  output logic                 tmo
);

  localparam int PTR_W = $clog2(N);

  if (N < 2 || N > 8 || GAP < 1 || GAP > 15 || MAX_HOLD < 1) begin : g_bad_param
    $error("oc_bus_arbiter: parameter out of range");
  end

  arb_state_e             state_q, state_d;
  logic [N-1:0]           gnt_q, gnt_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   busy_q, busy_d;
  logic                   fault_q, fault_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  logic                   owner_req;
  logic                   release_now;

`ifdef OCARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   tmo_q, tmo_d;
  logic                   hold_expired;

  assign hold_expired = (hold_cnt_q == HOLD_W'(MAX_HOLD));
`endif

  rr_pick #(
    .N     (N),
    .IDX_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req = req[owner_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    fault_d     = fault_q;
    gap_cnt_d   = gap_cnt_q;
    release_now = 1'b0;
`ifdef OCARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    tmo_d       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Nobody may drive the line here, so a low level means a stuck driver.
        if (!line) fault_d = 1'b1;
        if (pick_found) begin
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
`ifdef OCARB_TIMEOUT_EN
          hold_cnt_d = HOLD_W'(1);
`endif
        end
      end

      ST_GRANT: begin
        if (!owner_req) begin
          release_now = 1'b1;
        end
`ifdef OCARB_TIMEOUT_EN
        else if (hold_expired) begin
          release_now = 1'b1;
          tmo_d       = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_CNT_W'(1)) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Releasing owner drops to lowest priority; pullup gets GAP cycles.
    if (release_now) begin
      gnt_d     = '0;
      ptr_d     = PTR_W'(rr_next(int'(owner_q), N));
      gap_cnt_d = GAP_CNT_W'(GAP);
      state_d   = ST_GAP;
`ifdef OCARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      gap_cnt_q <= '0;
`ifdef OCARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef OCARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign fault = fault_q;
`ifdef OCARB_TIMEOUT_EN
  assign tmo   = tmo_q;
`else
  assign tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_oc_bus_arbiter.sv
// Scoreboard bench for oc_bus_arbiter (N=4, GAP=2, MAX_HOLD=16): directed
// per-edge vectors queue their expected outputs, a negedge monitor checks them.
module tb_oc_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       line = 1'b1;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy, fault, tmo;

  always #5 clk = ~clk;

  oc_bus_arbiter #(
    .N        (4),
    .GAP      (2),
    .MAX_HOLD (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .line  (line),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .fault (fault),
    .tmo   (tmo)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       fault;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_no    = 0;

  exp_t       mon_e;
  int         mon_id;
  logic [3:0] prev_gnt = 4'b0000;
  int         zeros    = 0;

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic ln,
                      input logic [3:0] eg, input logic [1:0] eo,
                      input logic eb, input logic ef, input logic et);
    rst  = r;
    req  = rq;
    line = ln;
    @(posedge clk);
    exp_q.push_back('{gnt: eg, owner: eo, busy: eb, fault: ef, tmo: et});
    id_q.push_back(step_no);
    step_no++;
    #1;
  endtask

  task automatic step_n(input int n, input logic r, input logic [3:0] rq,
                        input logic ln, input logic [3:0] eg, input logic [1:0] eo,
                        input logic eb, input logic ef, input logic et);
    repeat (n) step(r, rq, ln, eg, eo, eb, ef, et);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_id = id_q.pop_front();
      compared++;
      if ({gnt, owner, busy, fault, tmo} !== mon_e) begin
        mismatched++;
        $display("FAIL vec%0d: got gnt=%b owner=%0d busy=%b fault=%b tmo=%b, want gnt=%b owner=%0d busy=%b fault=%b tmo=%b",
                 mon_id, gnt, owner, busy, fault, tmo,
                 mon_e.gnt, mon_e.owner, mon_e.busy, mon_e.fault, mon_e.tmo);
      end
    end

    compared++;
    if (!$onehot0(gnt)) begin
      mismatched++;
      $display("FAIL onehot0: gnt=%b is multi-hot", gnt);
    end

    if (rst) begin
      prev_gnt = 4'b0000;
      zeros    = 0;
    end else if (gnt == 4'b0000) begin
      zeros++;
    end else begin
      if (prev_gnt != 4'b0000 && gnt != prev_gnt) begin
        compared++;
        if (zeros < 2) begin
          mismatched++;
          $display("FAIL handover: gnt %b -> %b after %0d idle cycles, need >= 2",
                   prev_gnt, gnt, zeros);
        end
      end
      prev_gnt = gnt;
      zeros    = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Reset, then quiet idle.
    step_n(2,  1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step_n(10, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Single grant; line low while owned/in gap must not raise fault.
    step  (    1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    step_n(2,  1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    step  (    1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

    // Round robin with all four requesting; each owner releases for one edge.
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step_n(3, 1'b0, 4'b1111, 1'b1, 4'(1 << k), 2'(k), 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'b1111 & ~4'(1 << k), 1'b1, 4'b0000, 2'(k), 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'(k), 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'(k), 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Stuck line in IDLE: sticky fault, arbitration continues from ptr=1.
    step  (    1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    step_n(2,  1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    step_n(2,  1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    step_n(2,  1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
    step  (    1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
    step  (    1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-grant and mid-gap.
    step(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Requester 1 holds forever while requester 3 waits.
`ifdef OCARB_TIMEOUT_EN
    step_n(16, 1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1);
    step  (    1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    step_n(2,  1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    step_n(2,  1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
`else
    step_n(21, 1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    step_n(2,  1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    step  (    1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
`endif

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
